// File: rtl/sa_col_collector_if.sv
//------------------------------------------------------------------------------
// Module   : sa_col_collector_if
// Brief    : Bottom-edge down-data and result-row stream bundle for the
//            systolic array column collector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sa_col_collector_if #(
  parameter int L_WIDTH = 32,
  parameter int COLS    = 4
);
  logic                      SA_mode;
  logic                      SA_clear;
  logic [COLS-1:0]           col_en;
  logic [COLS*L_WIDTH-1:0]   col_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*L_WIDTH-1:0]   out_data;
  logic [15:0]               rows_out;
  logic                      overflow;
  logic                      busy;

  modport master (
    output SA_mode, SA_clear, col_en, col_data, out_ready,
    input  out_valid, out_data, rows_out, overflow, busy
  );

  modport slave (
    input  SA_mode, SA_clear, col_en, col_data, out_ready,
    output out_valid, out_data, rows_out, overflow, busy
  );
endinterface

`default_nettype wire

// File: rtl/sa_col_collector.sv
//------------------------------------------------------------------------------
// Module   : sa_col_collector
// Brief    : De-skews bottom-row PE outputs into per-column FIFOs and emits
//            aligned result rows. Optional macro SA_COLLECTOR_RELU_EN zeroes
//            negative lanes on out_data.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sa_col_collector #(
  parameter int L_WIDTH = 32,
  parameter int COLS    = 4,
  parameter int DEPTH   = 8
) (
  input  logic              SA_clk,
  input  logic              SA_rst,
  sa_col_collector_if.slave bus
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEPTH);

  logic [COLS-1:0]         w_nonempty;
  logic [COLS-1:0]         w_drop;
  logic [COLS*L_WIDTH-1:0] w_out_data;
  logic                    w_valid;
  logic                    w_pop;
  logic [15:0]             r_rows_out;
  logic                    r_overflow;

  assign w_valid = &w_nonempty;
  assign w_pop   = w_valid & bus.out_ready & ~bus.SA_clear;

  generate
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [L_WIDTH-1:0] r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_wr_ptr;
      logic [c_PTR_W-1:0] r_rd_ptr;
      logic [c_CNT_W-1:0] r_cnt;
      logic               w_push;
      logic               w_full;
      logic               w_wr;
      logic [L_WIDTH-1:0] w_head;

      assign w_push = bus.col_en[c] & ~bus.SA_mode & ~bus.SA_clear;
      assign w_full = (r_cnt == c_CNT_MAX);
      // A full FIFO still takes the write when the row pop frees a slot.
      assign w_wr   = w_push & (~w_full | w_pop);
      assign w_drop[c]     = w_push & w_full & ~w_pop;
      assign w_nonempty[c] = (r_cnt != '0);
      assign w_head        = r_mem[r_rd_ptr];

`ifdef SA_COLLECTOR_RELU_EN
      assign w_out_data[c*L_WIDTH +: L_WIDTH] = w_head[L_WIDTH-1] ? '0 : w_head;
`else
      assign w_out_data[c*L_WIDTH +: L_WIDTH] = w_head;
`endif

      always_ff @(posedge SA_clk) begin
        if (SA_rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end else if (bus.SA_clear) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.col_data[c*L_WIDTH +: L_WIDTH];
            r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
          end
          if (w_wr & ~w_pop) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end else if (~w_wr & w_pop) begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge SA_clk) begin
    if (SA_rst || bus.SA_clear) begin
      r_rows_out <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rows_out <= r_rows_out + 16'd1;
      end
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_out_data;
  assign bus.busy      = |w_nonempty;
  assign bus.rows_out  = r_rows_out;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sa_col_collector.sv
//------------------------------------------------------------------------------
// Module   : tb_sa_col_collector
// Brief    : Self-checking bench for sa_col_collector (queue model plus
//            directed scenarios). Honors SA_COLLECTOR_RELU_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sa_col_collector;

  localparam int c_LW    = 32;
  localparam int c_COLS  = 4;
  localparam int c_DEPTH = 8;

  logic SA_clk;
  logic SA_rst;

  sa_col_collector_if #(.L_WIDTH(c_LW), .COLS(c_COLS)) bus ();

  sa_col_collector #(.L_WIDTH(c_LW), .COLS(c_COLS), .DEPTH(c_DEPTH)) dut (
    .SA_clk (SA_clk),
    .SA_rst (SA_rst),
    .bus    (bus.slave)
  );

  initial SA_clk = 1'b0;
  always #5 SA_clk = ~SA_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq [c_COLS][$];
  logic [15:0] m_rows = '0;
  logic        m_ovf  = 1'b0;
  int          tbl [0:15][0:3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_exp(input logic [31:0] v);
`ifdef SA_COLLECTOR_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  // Reference model: plain queues updated from the inputs seen at each edge.
  always @(posedge SA_clk) begin
    bit pop;
    bit full [c_COLS];
    if (SA_rst || bus.SA_clear) begin
      for (int c = 0; c < c_COLS; c++) mq[c].delete();
      m_rows = '0;
      m_ovf  = 1'b0;
    end else begin
      pop = bus.out_ready;
      for (int c = 0; c < c_COLS; c++) begin
        if (mq[c].size() == 0) pop = 0;
        full[c] = (mq[c].size() >= c_DEPTH);
      end
      if (pop) begin
        for (int c = 0; c < c_COLS; c++) void'(mq[c].pop_front());
        m_rows = m_rows + 16'd1;
      end
      for (int c = 0; c < c_COLS; c++) begin
        if (bus.col_en[c] && !bus.SA_mode) begin
          if (!full[c] || pop) mq[c].push_back(bus.col_data[c*c_LW +: c_LW]);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge SA_clk) begin
    logic         ev;
    logic         eb;
    logic [127:0] ed;
    ev = 1'b1;
    eb = 1'b0;
    ed = '0;
    for (int c = 0; c < c_COLS; c++) begin
      if (mq[c].size() == 0) ev = 1'b0;
      else begin
        eb = 1'b1;
        ed[c*c_LW +: c_LW] = lane_exp(mq[c][0]);
      end
    end
    chk("out_valid", bus.out_valid, ev);
    chk("busy", bus.busy, eb);
    chk("rows_out", bus.rows_out, m_rows);
    chk("overflow", bus.overflow, m_ovf);
    if (ev) chk("out_data", bus.out_data, ed);
  end

  task automatic tick();
    @(posedge SA_clk);
    #1;
  endtask

  // Column c pushes row r at step r+c, mimicking the array's skew.
  task automatic skew_stream(input int nrows);
    for (int k = 0; k < nrows + c_COLS - 1; k++) begin
      bus.col_en   = '0;
      bus.col_data = '0;
      for (int c = 0; c < c_COLS; c++) begin
        if (k - c >= 0 && k - c < nrows) begin
          bus.col_en[c] = 1'b1;
          bus.col_data[c*c_LW +: c_LW] = tbl[k-c][c];
        end
      end
      tick();
    end
    bus.col_en   = '0;
    bus.col_data = '0;
  endtask

  task automatic push_aligned(input int nrows, input int base);
    for (int r = 0; r < nrows; r++) begin
      bus.col_en = '1;
      for (int c = 0; c < c_COLS; c++) bus.col_data[c*c_LW +: c_LW] = base + r*4 + c;
      tick();
    end
    bus.col_en   = '0;
    bus.col_data = '0;
  endtask

  task automatic fresh_row_check();
    logic [127:0] lit;
`ifdef SA_COLLECTOR_RELU_EN
    lit = {32'd0, 32'd30, 32'd0, 32'd10};
`else
    lit = {32'hFFFFFFD8, 32'd30, 32'hFFFFFFEC, 32'd10};
`endif
    tbl[0][0] = 10; tbl[0][1] = -20; tbl[0][2] = 30; tbl[0][3] = -40;
    bus.out_ready = 1'b1;
    skew_stream(1);
    chk("skew_valid_at_t4", bus.out_valid, 1'b1);
    chk("skew_row_data", bus.out_data, lit);
    tick();
    chk("skew_valid_one_cycle", bus.out_valid, 1'b0);
    chk("skew_rows_out", bus.rows_out, 16'd1);
  endtask

  initial begin
    SA_rst        = 1'b1;
    bus.SA_mode   = 1'b0;
    bus.SA_clear  = 1'b0;
    bus.col_en    = '0;
    bus.col_data  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rows", bus.rows_out, 16'd0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_data", bus.out_data, 128'd0);
    SA_rst = 1'b0;

    // Single skewed row
    fresh_row_check();

    // Backpressure: 8 skewed rows held, then drained back to back
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < c_COLS; c++)
        tbl[r][c] = (c % 2 == 1) ? -(r*16 + c + 1) : (r*16 + c + 1);
    bus.out_ready = 1'b0;
    skew_stream(8);
    chk("bp_head_lane0", bus.out_data[31:0], 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_valid_consecutive", bus.out_valid, 1'b1);
      tick();
    end
    chk("bp_drained_valid", bus.out_valid, 1'b0);
    chk("bp_busy", bus.busy, 1'b0);
    chk("bp_ovf", bus.overflow, 1'b0);
    chk("bp_rows", bus.rows_out, 16'd9);

    // Overflow on column 0: the 9th value must be dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.col_en = 4'b0001;
      bus.col_data = '0;
      bus.col_data[31:0] = 500 + i;
      tick();
    end
    bus.col_en = '0;
    chk("ovf_set", bus.overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bus.col_en = 4'b1110;
      for (int c = 1; c < c_COLS; c++) bus.col_data[c*c_LW +: c_LW] = 600 + i;
      tick();
    end
    bus.col_en = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_col0_value", bus.out_data[31:0], 32'(500 + i));
      tick();
    end
    chk("ovf_9th_absent", bus.out_valid, 1'b0);
    chk("ovf_rows", bus.rows_out, 16'd17);

    // Full FIFOs with a simultaneous push and pop
    bus.out_ready = 1'b0;
    bus.SA_clear = 1'b1;
    tick();
    bus.SA_clear = 1'b0;
    chk("clr_ovf", bus.overflow, 1'b0);
    chk("clr_rows", bus.rows_out, 16'd0);
    push_aligned(8, 700);
    bus.out_ready = 1'b1;
    push_aligned(1, 800);
    bus.out_ready = 1'b0;
    chk("full_pp_ovf", bus.overflow, 1'b0);
    chk("full_pp_head", bus.out_data[31:0], 32'd704);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("full_pp_eight_left", bus.out_valid, 1'b0);
    chk("full_pp_rows", bus.rows_out, 16'd9);

    // Weight-store mode masks all pushes
    bus.out_ready = 1'b0;
    bus.SA_mode = 1'b1;
    bus.col_en = '1;
    bus.col_data = {32'd1, 32'd2, 32'd3, 32'd4};
    for (int i = 0; i < 5; i++) tick();
    bus.SA_mode = 1'b0;
    bus.col_en = '0;
    chk("mode_busy", bus.busy, 1'b0);
    chk("mode_valid", bus.out_valid, 1'b0);

    // Clear with 3 rows buffered
    push_aligned(3, 900);
    chk("pre_clr_busy", bus.busy, 1'b1);
    bus.SA_clear = 1'b1;
    tick();
    bus.SA_clear = 1'b0;
    chk("clr3_valid", bus.out_valid, 1'b0);
    chk("clr3_rows", bus.rows_out, 16'd0);
    chk("clr3_ovf", bus.overflow, 1'b0);
    chk("clr3_busy", bus.busy, 1'b0);
    fresh_row_check();

    // Reset with 3 rows buffered and overflow pending
    bus.out_ready = 1'b0;
    push_aligned(3, 1000);
    for (int i = 0; i < 6; i++) begin
      bus.col_en = 4'b0001;
      bus.col_data[31:0] = 1100 + i;
      tick();
    end
    bus.col_en = '0;
    chk("pre_rst_ovf", bus.overflow, 1'b1);
    SA_rst = 1'b1;
    tick();
    SA_rst = 1'b0;
    chk("rst3_valid", bus.out_valid, 1'b0);
    chk("rst3_rows", bus.rows_out, 16'd0);
    chk("rst3_ovf", bus.overflow, 1'b0);
    chk("rst3_busy", bus.busy, 1'b0);
    chk("rst3_data", bus.out_data, 128'd0);
    fresh_row_check();

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
